// File: rtl/eject_buffer.sv
// Ejection buffer between a mesh router's local port and the node receiver.
// It accepts flits by write_req/w_ack, queues correctly routed flits in a FWFT FIFO and counts misroutes.
module eject_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  my_x,
  input  logic [2:0]  my_y,
  input  logic        write_req,
  input  logic [63:0] eject,
  output logic        w_ack,
  output logic        full,
  output logic        rd_valid,
  output logic [63:0] rd_data,
  input  logic        rd_ready,
  output logic [31:0] rcv_cnt,
  output logic [15:0] misroute_cnt
);

  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [63:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic           w_ack_q, w_ack_d;
  logic [31:0]    rcv_cnt_q, rcv_cnt_d;
  logic [15:0]    misroute_q, misroute_d;

  logic accept;
  logic dest_ok;
  logic push;
  logic pop;

  assign full     = (count_q == FULL_COUNT);
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign w_ack    = w_ack_q;
  assign rcv_cnt  = rcv_cnt_q;
  assign misroute_cnt = misroute_q;

  // The full check comes before the destination check, so a misroute is also blocked when full.
  assign accept  = write_req && !w_ack_q && !full && !reset;
  assign dest_ok = (eject[63:61] == my_x) && (eject[60:58] == my_y);
  assign push    = accept && dest_ok;
  assign pop     = rd_valid && rd_ready;

  always_comb begin
    w_ack_d    = accept;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rcv_cnt_d  = rcv_cnt_q;
    misroute_d = misroute_q;
    if (push) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      rcv_cnt_d = rcv_cnt_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (accept && !dest_ok && (misroute_q != 16'hFFFF)) begin
      misroute_d = misroute_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      w_ack_q    <= 1'b0;
      rcv_cnt_q  <= '0;
      misroute_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      w_ack_q    <= w_ack_d;
      rcv_cnt_q  <= rcv_cnt_d;
      misroute_q <= misroute_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= eject;
    end
  end

endmodule

// File: tb/tb_eject_buffer.sv
// Self-checking bench for eject_buffer: vector table plus hand-written corner sequences,
// with a scoreboard queue of expected delivered flits checked at every pop.
module tb_eject_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam logic [2:0] MY_X = 3'd3;
  localparam logic [2:0] MY_Y = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  my_x;
  logic [2:0]  my_y;
  logic        write_req;
  logic [63:0] eject;
  logic        w_ack;
  logic        full;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_ready;
  logic [31:0] rcv_cnt;
  logic [15:0] misroute_cnt;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] sbQ[$];

  typedef struct {
    logic [63:0] flit;
    logic [31:0] expRcv;
    logic [15:0] expMis;
  } vec_t;

  vec_t vecs[6];

  eject_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .reset(reset),
    .my_x(my_x),
    .my_y(my_y),
    .write_req(write_req),
    .eject(eject),
    .w_ack(w_ack),
    .full(full),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_ready(rd_ready),
    .rcv_cnt(rcv_cnt),
    .misroute_cnt(misroute_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] makeFlit(input logic [2:0] dx, input logic [2:0] dy, input logic [51:0] payload);
    return {dx, dy, 3'd1, 3'd2, payload};
  endfunction

  // A pop happens at the next rising edge whenever rd_valid && rd_ready hold here.
  always @(negedge clk) begin
    if (reset === 1'b0 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL pop_unexpected: got %0h, expected no data", rd_data);
      end else begin
        checkOutput("pop_data", rd_data, sbQ.pop_front());
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [63:0] flit, output bit acked);
    acked = 1'b0;
    write_req = 1'b1;
    eject = flit;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (w_ack === 1'b1) begin
        acked = 1'b1;
        break;
      end
    end
    write_req = 1'b0;
    if (!acked) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ack_timeout: got no w_ack, expected w_ack for %0h", flit);
    end else if (flit[63:61] == MY_X && flit[60:58] == MY_Y) begin
      sbQ.push_back(flit);
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    write_req = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_w_ack", w_ack, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rcv_cnt", rcv_cnt, 0);
    checkOutput("rst_misroute_cnt", misroute_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sbQ.delete();
  endtask

  task automatic drainFifo();
    bit emptied = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 5; i++) begin
      @(posedge clk); #1;
      if (rd_valid === 1'b0) begin
        emptied = 1'b1;
        break;
      end
    end
    rd_ready = 1'b0;
    checkOutput("drain_empty", {63'd0, emptied}, 1);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acked;
    logic [63:0] f;

    vecs[0] = '{64'h7400_0000_0000_00AB, 32'd1, 16'd0};
    vecs[1] = '{64'h5400_0000_0000_00CD, 32'd1, 16'd1};
    vecs[2] = '{64'h7000_0000_0000_0001, 32'd1, 16'd2};
    vecs[3] = '{64'hF400_0000_0000_0002, 32'd1, 16'd3};
    vecs[4] = '{64'h77F0_0000_0000_0003, 32'd2, 16'd3};
    vecs[5] = '{64'h7400_0000_0000_0004, 32'd3, 16'd3};

    my_x = MY_X;
    my_y = MY_Y;
    eject = '0;
    resetDut();

    // Single delivery
    applyStimulus(64'h7400_0000_0000_00AB, acked);
    checkOutput("single_rd_valid", rd_valid, 1);
    checkOutput("single_rd_data", rd_data, 64'h7400_0000_0000_00AB);
    checkOutput("single_rcv_cnt", rcv_cnt, 1);
    @(posedge clk); #1;
    checkOutput("single_w_ack_drop", w_ack, 0);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    checkOutput("single_after_pop", rd_valid, 0);

    // Misroute
    resetDut();
    applyStimulus(64'h5400_0000_0000_00CD, acked);
    checkOutput("mis_rd_valid", rd_valid, 0);
    checkOutput("mis_count", misroute_cnt, 1);
    checkOutput("mis_rcv_cnt", rcv_cnt, 0);
    @(posedge clk); #1;
    checkOutput("mis_w_ack_drop", w_ack, 0);
    checkOutput("mis_rd_valid_late", rd_valid, 0);

    // Vector table with the receiver always ready
    resetDut();
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].flit, acked);
      checkOutput("vec_rcv_cnt", rcv_cnt, vecs[i].expRcv);
      checkOutput("vec_misroute_cnt", misroute_cnt, vecs[i].expMis);
    end
    drainFifo();

    // Fill and back-pressure
    resetDut();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(makeFlit(MY_X, MY_Y, 52'(32 + i)), acked);
      checkOutput("fill_full", full, (i == DEPTH - 1) ? 64'd1 : 64'd0);
    end
    f = makeFlit(MY_X, MY_Y, 52'h5555);
    write_req = 1'b1;
    eject = f;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_no_ack", w_ack, 0);
    end
    checkOutput("bp_still_full", full, 1);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    checkOutput("bp_full_drop", full, 0);
    checkOutput("bp_no_ack_on_pop", w_ack, 0);
    @(posedge clk); #1;
    checkOutput("bp_ack_after_pop", w_ack, 1);
    sbQ.push_back(f);
    write_req = 1'b0;
    checkOutput("bp_full_again", full, 1);
    drainFifo();

    // Concurrent push/pop at peak rate, wrapping the pointers
    resetDut();
    rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(makeFlit(MY_X, MY_Y, 52'(100 + i)), acked);
    end
    drainFifo();
    checkOutput("stream_rcv_cnt", rcv_cnt, 12);
    checkOutput("stream_misroute_cnt", misroute_cnt, 0);

    // Misroute counter saturation
    resetDut();
    force dut.misroute_q = 16'hFFFE;
    @(negedge clk);
    release dut.misroute_q;
    @(posedge clk); #1;
    checkOutput("sat_preload", misroute_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(makeFlit(3'd2, MY_Y, 52'(200 + i)), acked);
      checkOutput("sat_value", misroute_cnt, 16'hFFFF);
    end
    @(posedge clk); #1;
    checkOutput("sat_hold", misroute_cnt, 16'hFFFF);
    checkOutput("sat_rcv_cnt", rcv_cnt, 0);

    // Reset mid-operation with a held request
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(makeFlit(MY_X, MY_Y, 52'(300 + i)), acked);
    end
    checkOutput("mid_queued", rd_valid, 1);
    f = makeFlit(MY_X, MY_Y, 52'h777);
    write_req = 1'b1;
    eject = f;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rd_valid", rd_valid, 0);
    checkOutput("mid_rcv_cnt", rcv_cnt, 0);
    checkOutput("mid_misroute_cnt", misroute_cnt, 0);
    checkOutput("mid_w_ack", w_ack, 0);
    sbQ.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_ack_after_reset", w_ack, 1);
    sbQ.push_back(f);
    write_req = 1'b0;
    checkOutput("mid_rd_valid_after", rd_valid, 1);
    checkOutput("mid_rd_data_after", rd_data, f);
    checkOutput("mid_rcv_after", rcv_cnt, 1);
    drainFifo();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
